// File: rtl/axis_sprite_gen_pkg.sv
// Shared colour constants, background mode encoding and FSM state type for the sprite generator.
package starsoc_params;

  localparam logic [11:0] COL_WHITE   = 12'hFFF;
  localparam logic [11:0] COL_YELLOW  = 12'hFF0;
  localparam logic [11:0] COL_CYAN    = 12'h0FF;
  localparam logic [11:0] COL_GREEN   = 12'h0F0;
  localparam logic [11:0] COL_MAGENTA = 12'hF0F;
  localparam logic [11:0] COL_RED     = 12'hF00;
  localparam logic [11:0] COL_BLUE    = 12'h00F;
  localparam logic [11:0] COL_BLACK   = 12'h000;

  typedef enum logic [1:0] {
    MODE_SOLID     = 2'd0,
    MODE_BARS      = 2'd1,
    MODE_CHECKER   = 2'd2,
    MODE_SOLID_ALT = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_HOLD   = 2'd2
  } state_e;

  function automatic logic [11:0] bar_color(input logic [2:0] idx);
    case (idx)
      3'd0:    return COL_WHITE;
      3'd1:    return COL_YELLOW;
      3'd2:    return COL_CYAN;
      3'd3:    return COL_GREEN;
      3'd4:    return COL_MAGENTA;
      3'd5:    return COL_RED;
      3'd6:    return COL_BLUE;
      default: return COL_BLACK;
    endcase
  endfunction

  function automatic logic [23:0] rgb444_to_888(input logic [11:0] c);
    return {c[11:8], c[11:8], c[7:4], c[7:4], c[3:0], c[3:0]};
  endfunction

endpackage

// File: rtl/axis_sprite_gen_if.sv
// AXI4-Stream video pixel bus (RGB888, tuser = start of frame, tlast = end of line).
interface axis_sprite_gen_if;
  logic [23:0] tdata;
  logic        tvalid;
  logic        tuser;
  logic        tlast;
  logic        tready;

  modport master (output tdata, tvalid, tuser, tlast, input tready);
  modport slave  (input tdata, tvalid, tuser, tlast, output tready);
endinterface

// File: rtl/axis_sprite_gen_sprite_hit.sv
// Combinational sprite coverage test with lowest-index priority; zero latency, no flow control.
module sprite_hit #(
  parameter int NUM_SPRITES = 4,
  parameter int SPRITE_W    = 20,
  parameter int SPRITE_H    = 40
) (
  input  logic [9:0]                   x,
  input  logic [9:0]                   y,
  input  logic [NUM_SPRITES-1:0][9:0]  sprite_x,
  input  logic [NUM_SPRITES-1:0][9:0]  sprite_y,
  input  logic [NUM_SPRITES-1:0][11:0] sprite_color,
  output logic                         hit,
  output logic [11:0]                  color
);

  localparam logic [10:0] SW = 11'(SPRITE_W);
  localparam logic [10:0] SH = 11'(SPRITE_H);

  // Walk from highest to lowest index so the lowest covering sprite is written last and wins.
  always_comb begin
    hit   = 1'b0;
    color = 12'h000;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (({1'b0, x} >= {1'b0, sprite_x[i]}) && ({1'b0, x} < ({1'b0, sprite_x[i]} + SW)) &&
          ({1'b0, y} >= {1'b0, sprite_y[i]}) && ({1'b0, y} < ({1'b0, sprite_y[i]} + SH))) begin
        hit   = 1'b1;
        color = sprite_color[i];
      end
    end
  end

endmodule

// File: rtl/axis_sprite_gen.sv
// Test-pattern + sprite video source on AXI4-Stream; first beat 1 cycle after gen_en, then 1 pixel/clk.
// Backpressure: registered output holds while tready=0; frame config is shadowed at pixel (0,0).
module axis_sprite_gen
  import starsoc_params::*;
#(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int NUM_SPRITES = 4,
  parameter int SPRITE_W    = 20,
  parameter int SPRITE_H    = 40
) (
  input  logic                         pixel_clk,
  input  logic                         reset_n,
  input  logic                         gen_en,
  input  logic [1:0]                   mode,
  input  logic [11:0]                  bg_color,
  input  logic [NUM_SPRITES-1:0][9:0]  sprite_x,
  input  logic [NUM_SPRITES-1:0][9:0]  sprite_y,
  input  logic [NUM_SPRITES-1:0][11:0] sprite_color,
  axis_sprite_gen_if.master            axis,
  output logic [15:0]                  frame_cnt
);

  localparam logic [9:0] X_LAST = 10'(H_ACTIVE - 1);
  localparam logic [9:0] Y_LAST = 10'(V_ACTIVE - 1);

  state_e      state;
  logic [9:0]  x, y;
  logic [23:0] tdata_q;
  logic        tvalid_q, tuser_q, tlast_q;

  mode_e                         sh_mode;
  logic [11:0]                   sh_bg;
  logic [NUM_SPRITES-1:0][9:0]   sh_sx, sh_sy;
  logic [NUM_SPRITES-1:0][11:0]  sh_sc;

  logic                          xfer, frame_end, start_frame;
  logic [9:0]                    nx, ny;
  mode_e                         c_mode;
  logic [11:0]                   c_bg;
  logic [NUM_SPRITES-1:0][9:0]   c_sx, c_sy;
  logic [NUM_SPRITES-1:0][11:0]  c_sc;
  logic                          spr_hit;
  logic [11:0]                   spr_color, bg_pix, pix;
  logic [2:0]                    bar_idx;

  assign axis.tdata  = tdata_q;
  assign axis.tvalid = tvalid_q;
  assign axis.tuser  = tuser_q;
  assign axis.tlast  = tlast_q;

  assign xfer        = tvalid_q & axis.tready;
  assign frame_end   = xfer && (x == X_LAST) && (y == Y_LAST);
  assign start_frame = gen_en && ((state == ST_IDLE) || frame_end);

  // A pixel loaded at frame start must use the live config, since the shadows update on that same edge.
  assign c_mode = start_frame ? mode_e'(mode) : sh_mode;
  assign c_bg   = start_frame ? bg_color      : sh_bg;
  assign c_sx   = start_frame ? sprite_x      : sh_sx;
  assign c_sy   = start_frame ? sprite_y      : sh_sy;
  assign c_sc   = start_frame ? sprite_color  : sh_sc;

  always_comb begin
    nx = 10'd0;
    ny = 10'd0;
    if (!start_frame && state != ST_IDLE) begin
      if (x == X_LAST) begin
        ny = (y == Y_LAST) ? 10'd0 : y + 10'd1;
      end else begin
        nx = x + 10'd1;
        ny = y;
      end
    end
  end

  sprite_hit #(
    .NUM_SPRITES (NUM_SPRITES),
    .SPRITE_W    (SPRITE_W),
    .SPRITE_H    (SPRITE_H)
  ) u_sprite_hit (
    .x            (nx),
    .y            (ny),
    .sprite_x     (c_sx),
    .sprite_y     (c_sy),
    .sprite_color (c_sc),
    .hit          (spr_hit),
    .color        (spr_color)
  );

  // Checker squares are 32 pixels, so bit 5 of each coordinate selects the square parity.
  always_comb begin
    bar_idx = 3'((32'(nx) * 32'd8) / 32'(H_ACTIVE));
    case (c_mode)
      MODE_BARS:    bg_pix = bar_color(bar_idx);
      MODE_CHECKER: bg_pix = (nx[5] ^ ny[5]) ? COL_BLACK : c_bg;
      default:      bg_pix = c_bg;
    endcase
    pix = spr_hit ? spr_color : bg_pix;
  end

  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      x         <= 10'd0;
      y         <= 10'd0;
      tdata_q   <= 24'd0;
      tvalid_q  <= 1'b0;
      tuser_q   <= 1'b0;
      tlast_q   <= 1'b0;
      frame_cnt <= 16'd0;
      sh_mode   <= MODE_SOLID;
      sh_bg     <= 12'd0;
      sh_sx     <= '0;
      sh_sy     <= '0;
      sh_sc     <= '0;
    end else begin
      if (start_frame) begin
        sh_mode <= mode_e'(mode);
        sh_bg   <= bg_color;
        sh_sx   <= sprite_x;
        sh_sy   <= sprite_y;
        sh_sc   <= sprite_color;
      end
      if (frame_end) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
      case (state)
        ST_IDLE: begin
          if (gen_en) begin
            tdata_q  <= rgb444_to_888(pix);
            tvalid_q <= 1'b1;
            tuser_q  <= 1'b1;
            tlast_q  <= (nx == X_LAST);
            x        <= nx;
            y        <= ny;
            state    <= ST_ACTIVE;
          end
        end
        ST_ACTIVE, ST_HOLD: begin
          if (!xfer) begin
            state <= ST_HOLD;
          end else if (frame_end && !gen_en) begin
            tvalid_q <= 1'b0;
            tuser_q  <= 1'b0;
            tlast_q  <= 1'b0;
            x        <= 10'd0;
            y        <= 10'd0;
            state    <= ST_IDLE;
          end else begin
            tdata_q  <= rgb444_to_888(pix);
            tvalid_q <= 1'b1;
            tuser_q  <= (nx == 10'd0) && (ny == 10'd0);
            tlast_q  <= (nx == X_LAST);
            x        <= nx;
            y        <= ny;
            state    <= ST_ACTIVE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_sprite_gen.sv
// Scoreboard bench for axis_sprite_gen on a reduced 128x96 raster.
module tb_axis_sprite_gen;
  import starsoc_params::*;

  localparam int H    = 128;
  localparam int V    = 96;
  localparam int NS   = 4;
  localparam int SW   = 20;
  localparam int SH   = 40;
  localparam int NPIX = H * V;
  localparam logic [11:0] BARS [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                                       12'hF0F, 12'hF00, 12'h00F, 12'h000};

  typedef struct packed {
    logic        user;
    logic        last;
    logic [23:0] data;
  } beat_t;

  logic                   pixel_clk = 1'b0;
  logic                   reset_n   = 1'b0;
  logic                   gen_en    = 1'b0;
  logic [1:0]             mode      = 2'd0;
  logic [11:0]            bg_color  = 12'd0;
  logic [NS-1:0][9:0]     sprite_x  = '0;
  logic [NS-1:0][9:0]     sprite_y  = '0;
  logic [NS-1:0][11:0]    sprite_color = '0;
  logic [15:0]            frame_cnt;

  axis_sprite_gen_if axis();

  axis_sprite_gen #(
    .H_ACTIVE (H), .V_ACTIVE (V), .NUM_SPRITES (NS), .SPRITE_W (SW), .SPRITE_H (SH)
  ) dut (
    .pixel_clk    (pixel_clk),
    .reset_n      (reset_n),
    .gen_en       (gen_en),
    .mode         (mode),
    .bg_color     (bg_color),
    .sprite_x     (sprite_x),
    .sprite_y     (sprite_y),
    .sprite_color (sprite_color),
    .axis         (axis),
    .frame_cnt    (frame_cnt)
  );

  always #5 pixel_clk = ~pixel_clk;

  int          vectors     = 0;
  int          miscompares = 0;
  beat_t       exp_q[$];
  logic [23:0] frame_mem [2][NPIX];
  int          mon_x = 0, mon_y = 0, mon_bank = 0;
  int          frames_seen = 0, beats_seen = 0, tlast_seen = 0;
  bit          held_vld = 1'b0;
  beat_t       held;

  function automatic logic [23:0] model_pixel(int xx, int yy);
    logic [11:0] c;
    bit          found;
    case (mode)
      2'd1:    c = BARS[(xx * 8) / H];
      2'd2:    c = (((xx / 32) + (yy / 32)) % 2 == 0) ? bg_color : 12'h000;
      default: c = bg_color;
    endcase
    found = 1'b0;
    for (int i = 0; i < NS; i++) begin
      if (!found && xx >= int'(sprite_x[i]) && xx < int'(sprite_x[i]) + SW &&
          yy >= int'(sprite_y[i]) && yy < int'(sprite_y[i]) + SH) begin
        c     = sprite_color[i];
        found = 1'b1;
      end
    end
    return {c[11:8], c[11:8], c[7:4], c[7:4], c[3:0], c[3:0]};
  endfunction

  task automatic push_frame();
    for (int yy = 0; yy < V; yy++)
      for (int xx = 0; xx < H; xx++)
        exp_q.push_back(beat_t'({(xx == 0 && yy == 0), (xx == H - 1), model_pixel(xx, yy)}));
  endtask

  // Scoreboard: a beat transfers on the coming rising edge when tvalid and tready are both high now.
  always @(negedge pixel_clk) begin : monitor
    beat_t got, exp;
    got = {axis.tuser, axis.tlast, axis.tdata};
    if (!reset_n) begin
      mon_x    = 0;
      mon_y    = 0;
      held_vld = 1'b0;
    end else begin
      if (held_vld) begin
        vectors++;
        if (!axis.tvalid || got !== held) begin
          miscompares++;
          $display("FAIL stall_hold at (%0d,%0d): got vld=%b beat=%h required vld=1 beat=%h",
                   mon_x, mon_y, axis.tvalid, got, held);
        end
      end
      held_vld = axis.tvalid && !axis.tready;
      held     = got;
      if (axis.tvalid && axis.tready) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL beat_unexpected at (%0d,%0d): got %h, required no beat", mon_x, mon_y, got);
        end else begin
          exp = exp_q.pop_front();
          if (got !== exp) begin
            miscompares++;
            $display("FAIL beat (%0d,%0d): got user/last/data %h required %h", mon_x, mon_y, got, exp);
          end
        end
        frame_mem[mon_bank][mon_y * H + mon_x] = axis.tdata;
        beats_seen++;
        if (axis.tlast) tlast_seen++;
        if (mon_x == H - 1) begin
          mon_x = 0;
          if (mon_y == V - 1) begin
            mon_y = 0;
            mon_bank ^= 1;
            frames_seen++;
          end else begin
            mon_y++;
          end
        end else begin
          mon_x++;
        end
      end
    end
  end

  task automatic wait_tvalid_low(input int budget, output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(posedge pixel_clk); #1;
      if (!axis.tvalid) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic set_sprites_off();
    for (int i = 0; i < NS; i++) begin
      sprite_x[i]     = 10'd1000;
      sprite_y[i]     = 10'd1000;
      sprite_color[i] = 12'hABC;
    end
  endtask

  task automatic test_reset();
    int b0, t0;
    bit to;
    reset_n = 1'b0; gen_en = 1'b1; axis.tready = 1'b1;
    mode = 2'd0; bg_color = 12'h00F; set_sprites_off();
    repeat (3) @(posedge pixel_clk);
    @(negedge pixel_clk);
    vectors += 5;
    if (axis.tvalid !== 1'b0) begin miscompares++; $display("FAIL rst_tvalid got %b required 0", axis.tvalid); end
    if (axis.tdata !== 24'd0) begin miscompares++; $display("FAIL rst_tdata got %h required 000000", axis.tdata); end
    if (axis.tuser !== 1'b0) begin miscompares++; $display("FAIL rst_tuser got %b required 0", axis.tuser); end
    if (axis.tlast !== 1'b0) begin miscompares++; $display("FAIL rst_tlast got %b required 0", axis.tlast); end
    if (frame_cnt !== 16'd0) begin miscompares++; $display("FAIL rst_frame_cnt got %0d required 0", frame_cnt); end
    b0 = beats_seen; t0 = tlast_seen;
    push_frame();
    @(posedge pixel_clk); #1 reset_n = 1'b1;
    @(negedge pixel_clk);
    vectors++;
    if (axis.tvalid !== 1'b0) begin miscompares++; $display("FAIL pre_start_tvalid got %b required 0", axis.tvalid); end
    @(posedge pixel_clk); #1;
    vectors += 3;
    if (axis.tvalid !== 1'b1) begin miscompares++; $display("FAIL first_tvalid got %b required 1", axis.tvalid); end
    if (axis.tdata !== 24'h0000FF) begin miscompares++; $display("FAIL first_tdata got %h required 0000FF", axis.tdata); end
    if (axis.tuser !== 1'b1) begin miscompares++; $display("FAIL first_tuser got %b required 1", axis.tuser); end
    gen_en = 1'b0;
    wait_tvalid_low(NPIX + 20, to);
    vectors += 6;
    if (to) begin miscompares++; $display("FAIL solid_timeout got tvalid=1 required 0 within budget"); end
    if (beats_seen - b0 != NPIX) begin miscompares++; $display("FAIL solid_beats got %0d required %0d", beats_seen - b0, NPIX); end
    if (tlast_seen - t0 != V) begin miscompares++; $display("FAIL solid_tlast got %0d required %0d", tlast_seen - t0, V); end
    if (frame_cnt !== 16'd1) begin miscompares++; $display("FAIL solid_frame_cnt got %0d required 1", frame_cnt); end
    if (dut.state !== ST_IDLE) begin miscompares++; $display("FAIL solid_idle got %0d required %0d", dut.state, ST_IDLE); end
    if (exp_q.size() != 0) begin miscompares++; $display("FAIL solid_queue got %0d left required 0", exp_q.size()); end
  endtask

  task automatic test_sprites();
    int bk;
    bit to;
    bg_color = 12'h333; set_sprites_off();
    sprite_x[0] = 10'd100; sprite_y[0] = 10'd50; sprite_color[0] = 12'h0FF;
    bk = mon_bank;
    push_frame();
    gen_en = 1'b1;
    @(posedge pixel_clk); #1;
    gen_en = 1'b0;
    wait_tvalid_low(NPIX + 20, to);
    vectors += 7;
    if (to) begin miscompares++; $display("FAIL sprite_timeout got tvalid=1 required 0 within budget"); end
    if (frame_cnt !== 16'd2) begin miscompares++; $display("FAIL sprite_frame_cnt got %0d required 2", frame_cnt); end
    if (frame_mem[bk][50*H+100] !== 24'h00FFFF) begin miscompares++; $display("FAIL sprite_tl got %h required 00FFFF", frame_mem[bk][50*H+100]); end
    if (frame_mem[bk][89*H+119] !== 24'h00FFFF) begin miscompares++; $display("FAIL sprite_br got %h required 00FFFF", frame_mem[bk][89*H+119]); end
    if (frame_mem[bk][50*H+120] !== 24'h333333) begin miscompares++; $display("FAIL sprite_right got %h required 333333", frame_mem[bk][50*H+120]); end
    if (frame_mem[bk][90*H+100] !== 24'h333333) begin miscompares++; $display("FAIL sprite_below got %h required 333333", frame_mem[bk][90*H+100]); end
    if (frame_mem[bk][49*H+100] !== 24'h333333) begin miscompares++; $display("FAIL sprite_above got %h required 333333", frame_mem[bk][49*H+100]); end
  endtask

  task automatic test_back_to_back();
    int bk, stalls;
    bit to;
    bg_color = 12'h123;
    sprite_x[0] = 10'd60;  sprite_y[0] = 10'd60; sprite_color[0] = 12'hF00;
    sprite_x[1] = 10'd60;  sprite_y[1] = 10'd60; sprite_color[1] = 12'h0F0;
    sprite_x[2] = 10'd0;   sprite_y[2] = 10'd0;  sprite_color[2] = 12'h00F;
    sprite_x[3] = 10'd120; sprite_y[3] = 10'd90; sprite_color[3] = 12'hFFF;
    bk = mon_bank; stalls = 0;
    push_frame();
    gen_en = 1'b1;
    @(posedge pixel_clk); #1;
    gen_en = 1'b0;
    to = 1'b1;
    for (int i = 0; i < 6 * NPIX; i++) begin
      axis.tready = 1'($urandom_range(0, 1));
      if (axis.tvalid && !axis.tready) stalls++;
      @(posedge pixel_clk); #1;
      if (!axis.tvalid) begin
        to = 1'b0;
        break;
      end
    end
    axis.tready = 1'b1;
    vectors += 8;
    if (to) begin miscompares++; $display("FAIL b2b_timeout got tvalid=1 required 0 within budget"); end
    if (stalls == 0) begin miscompares++; $display("FAIL b2b_stalls got 0 required >0"); end
    if (frame_cnt !== 16'd3) begin miscompares++; $display("FAIL b2b_frame_cnt got %0d required 3", frame_cnt); end
    if (frame_mem[bk][65*H+65] !== 24'hFF0000) begin miscompares++; $display("FAIL b2b_priority got %h required FF0000", frame_mem[bk][65*H+65]); end
    if (frame_mem[bk][0] !== 24'h0000FF) begin miscompares++; $display("FAIL b2b_origin got %h required 0000FF", frame_mem[bk][0]); end
    if (frame_mem[bk][95*H+127] !== 24'hFFFFFF) begin miscompares++; $display("FAIL b2b_clip got %h required FFFFFF", frame_mem[bk][95*H+127]); end
    if (frame_mem[bk][30*H+30] !== 24'h112233) begin miscompares++; $display("FAIL b2b_bg got %h required 112233", frame_mem[bk][30*H+30]); end
    if (exp_q.size() != 0) begin miscompares++; $display("FAIL b2b_queue got %0d left required 0", exp_q.size()); end
  endtask

  task automatic test_mode_switch();
    int bk1, bk2, f0;
    bit to1, to2, to3;
    mode = 2'd1; bg_color = 12'h5A3; set_sprites_off();
    bk1 = mon_bank; bk2 = mon_bank ^ 1; f0 = frames_seen;
    push_frame();
    gen_en = 1'b1;
    to1 = 1'b1;
    for (int i = 0; i < NPIX; i++) begin
      @(posedge pixel_clk); #1;
      if (mon_y >= 50) begin to1 = 1'b0; break; end
    end
    mode = 2'd2;
    push_frame();
    to2 = 1'b1;
    for (int i = 0; i < 2 * NPIX; i++) begin
      @(posedge pixel_clk); #1;
      if (frames_seen > f0 && mon_y >= 10 && mon_x >= 10) begin to2 = 1'b0; break; end
    end
    gen_en = 1'b0;
    wait_tvalid_low(NPIX + 20, to3);
    vectors += 13;
    if (to1 || to2 || to3) begin miscompares++; $display("FAIL mode_timeout got %b%b%b required 000", to1, to2, to3); end
    if (frames_seen - f0 != 2) begin miscompares++; $display("FAIL mode_frames got %0d required 2", frames_seen - f0); end
    if (frame_cnt !== 16'd5) begin miscompares++; $display("FAIL mode_frame_cnt got %0d required 5", frame_cnt); end
    if (dut.state !== ST_IDLE) begin miscompares++; $display("FAIL mode_idle got %0d required %0d", dut.state, ST_IDLE); end
    if (frame_mem[bk1][60*H+20] !== 24'hFFFF00) begin miscompares++; $display("FAIL bars_yellow got %h required FFFF00", frame_mem[bk1][60*H+20]); end
    if (frame_mem[bk1][95*H+0] !== 24'hFFFFFF) begin miscompares++; $display("FAIL bars_white got %h required FFFFFF", frame_mem[bk1][95*H]); end
    if (frame_mem[bk1][70*H+100] !== 24'h0000FF) begin miscompares++; $display("FAIL bars_blue got %h required 0000FF", frame_mem[bk1][70*H+100]); end
    if (frame_mem[bk1][95*H+127] !== 24'h000000) begin miscompares++; $display("FAIL bars_black got %h required 000000", frame_mem[bk1][95*H+127]); end
    if (frame_mem[bk2][0] !== 24'h55AA33) begin miscompares++; $display("FAIL check_00 got %h required 55AA33", frame_mem[bk2][0]); end
    if (frame_mem[bk2][32] !== 24'h000000) begin miscompares++; $display("FAIL check_32_0 got %h required 000000", frame_mem[bk2][32]); end
    if (frame_mem[bk2][32*H+32] !== 24'h55AA33) begin miscompares++; $display("FAIL check_32_32 got %h required 55AA33", frame_mem[bk2][32*H+32]); end
    if (frame_mem[bk2][95*H+127] !== 24'h000000) begin miscompares++; $display("FAIL check_last got %h required 000000", frame_mem[bk2][95*H+127]); end
    if (exp_q.size() != 0) begin miscompares++; $display("FAIL mode_queue got %0d left required 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid_frame();
    int b0;
    bit to;
    mode = 2'd0; bg_color = 12'h0F0; set_sprites_off();
    push_frame();
    gen_en = 1'b1;
    b0 = beats_seen; to = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(posedge pixel_clk); #1;
      if (beats_seen - b0 >= 200) begin to = 1'b0; break; end
    end
    @(posedge pixel_clk); #1 reset_n = 1'b0;
    #1;
    vectors += 4;
    if (to) begin miscompares++; $display("FAIL mid_timeout got %0d beats required 200", beats_seen - b0); end
    if (axis.tvalid !== 1'b0) begin miscompares++; $display("FAIL mid_rst_tvalid got %b required 0", axis.tvalid); end
    if (axis.tdata !== 24'd0) begin miscompares++; $display("FAIL mid_rst_tdata got %h required 000000", axis.tdata); end
    if (frame_cnt !== 16'd0) begin miscompares++; $display("FAIL mid_rst_frame_cnt got %0d required 0", frame_cnt); end
    exp_q.delete();
    repeat (2) @(posedge pixel_clk);
    push_frame();
    #1 reset_n = 1'b1;
    @(posedge pixel_clk); #1;
    vectors += 3;
    if (axis.tvalid !== 1'b1) begin miscompares++; $display("FAIL restart_tvalid got %b required 1", axis.tvalid); end
    if (axis.tuser !== 1'b1) begin miscompares++; $display("FAIL restart_tuser got %b required 1", axis.tuser); end
    if (axis.tdata !== 24'h00FF00) begin miscompares++; $display("FAIL restart_tdata got %h required 00FF00", axis.tdata); end
    repeat (300) @(posedge pixel_clk);
    #1 reset_n = 1'b0;
    gen_en = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge pixel_clk);
  endtask

  initial begin
    axis.tready = 1'b1;
    test_reset();
    test_sprites();
    test_back_to_back();
    test_mode_switch();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/axis_sprite_gen.md
AXIS_SPRITE_GEN -- requirements
Module: axis_sprite_gen

Interface
REQ-001 Parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 Parameter V_ACTIVE, default 480, visible lines per frame.
REQ-003 Parameter NUM_SPRITES, default 4, number of rectangular sprites (1..8).
REQ-004 Parameter SPRITE_W, default 20, sprite width in pixels.
REQ-005 Parameter SPRITE_H, default 40, sprite height in lines.
REQ-006 Port pixel_clk, input, 1, pixel clock; the only clock.
REQ-007 Port reset_n, input, 1, asynchronous active-low reset.
REQ-008 Port gen_en, input, 1, frame generation enable.
REQ-009 Port mode, input, 2, background pattern select.
REQ-010 Port bg_color, input, 12, RGB444 solid background colour.
REQ-011 Port sprite_x, input, NUM_SPRITES x 10, sprite top-left x per sprite.
REQ-012 Port sprite_y, input, NUM_SPRITES x 10, sprite top-left y per sprite.
REQ-013 Port sprite_color, input, NUM_SPRITES x 12, RGB444 colour per sprite.
REQ-014 Port tdata, output, 24, RGB888 pixel {r,g,b}.
REQ-015 Port tvalid, output, 1, AXI4-Stream valid.
REQ-016 Port tuser, output, 1, start of frame, asserted on pixel (0,0) only.
REQ-017 Port tlast, output, 1, end of line, asserted on x = H_ACTIVE-1 only.
REQ-018 Port tready, input, 1, downstream ready.
REQ-019 Port frame_cnt, output, 16, count of completed frames; wraps at 0xFFFF.

Function
REQ-020 A beat SHALL transfer only on a pixel_clk edge where tvalid=1 and tready=1.
REQ-021 While tvalid=1 and tready=0, tdata, tuser and tlast SHALL hold stable and tvalid SHALL stay 1.
REQ-022 Pixel counters x (0..H_ACTIVE-1) and y (0..V_ACTIVE-1) SHALL advance only on transfer.
- x wraps to 0 and y increments after x = H_ACTIVE-1.
- y wraps to 0 after (H_ACTIVE-1, V_ACTIVE-1).
REQ-023 The FSM SHALL have three states: IDLE, ACTIVE and HOLD.
- IDLE: tvalid=0. Go to ACTIVE when gen_en=1.
- ACTIVE: streams pixels. On the last-pixel transfer, go to IDLE if gen_en=0, otherwise stay in ACTIVE.
- HOLD: ACTIVE sub-state entered while tvalid=1 and tready=0.
REQ-024 gen_en falling mid-frame SHALL NOT truncate the frame; the current frame always completes.
REQ-025 Leaving IDLE, the first beat (0,0) with tuser=1 SHALL present tvalid exactly 1 cycle after gen_en is sampled high.
REQ-026 Once in ACTIVE, the output register SHALL load the next pixel on the same edge as each transfer, so that tready held high gives one pixel per clock.
REQ-027 mode, bg_color, sprite_x, sprite_y and sprite_color SHALL be latched into shadow registers when pixel (0,0) is loaded, so they are constant for the whole frame.
REQ-028 Background selection by mode:
- 0: bg_color.
- 1: 8 vertical bars, bar index = x*8/H_ACTIVE, colours white, yellow, cyan, green, magenta, red, blue, black.
- 2: 32x32 checkerboard of bg_color and black, with the top-left square equal to bg_color.
- 3: treated as 0.
REQ-029 Sprite i covers sx_i <= x < sx_i+SPRITE_W and sy_i <= y < sy_i+SPRITE_H.
- Comparisons are evaluated at 11 bits so there is no wrap; sprites may extend beyond the visible area and are clipped.
REQ-030 When sprites overlap, the lowest sprite index SHALL win; any sprite SHALL override the background.
REQ-031 RGB444 SHALL expand to RGB888 by nibble replication ({n,n}).
REQ-032 frame_cnt SHALL increment on the transfer of the last pixel of a frame.

Reset
REQ-033 While reset_n=0, outputs SHALL be:
- tvalid=0, tdata=0, tuser=0, tlast=0.
- frame_cnt=0, FSM in IDLE, x=y=0.
- Shadow registers cleared.
REQ-034 Reset asserted mid-frame SHALL abort immediately with no partial-line completion; after release, the next frame SHALL start at (0,0) with tuser=1.

Structure
REQ-035 Colour constants, the mode encoding enum and the FSM state typedef SHALL live in starsoc_params.
REQ-036 Sprite hit and priority logic SHALL be one sub-module, sprite_hit, which is combinational and takes x, y and the shadow sprite arrays and returns hit and colour.

Verification
REQ-037 Reset release with gen_en=1, tready=1, mode=0, bg_color=0x00F, no sprites on-screen:
- First beat 1 cycle after enable, tdata=0x0000FF, tuser=1.
- 307200 beats, tlast every 640th beat, frame_cnt=1.
REQ-038 Sprite 0 at (100,50) colour 0x0FF:
- Beat (100,50) gives 0x00FFFF; (119,89) gives 0x00FFFF.
- (120,50) and (100,90) give background.
REQ-039 Sprites 0 and 1 both at (200,200), colours 0xF00 and 0x0F0: pixel (205,205) gives 0xFF0000.
REQ-040 tready toggled by a random 50% pattern over a full frame:
- tdata is stable during each stall.
- No pixel is dropped or duplicated; the beat sequence matches the tready=1 golden model.
REQ-041 gen_en dropped at pixel (10,10): the frame completes to (639,479), then tvalid=0 and the FSM is in IDLE.
REQ-042 mode changed 1->2 at pixel (0,100): the frame stays colour bars throughout; the next frame is checkerboard with (32,0)=black.
